// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell time-shared over WIDTH cycles.
// Optional signed-overflow output enabled by SERIAL_ADD_OVF_EN.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             p;
  logic             g;
  logic             s;
  logic             c;
  logic             last;
  logic             accept;

  assign p      = areg[0] ^ breg[0];
  assign g      = areg[0] & breg[0];
  assign s      = p ^ carry;
  assign c      = g | (p & carry);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = in_valid && in_ready;

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    res_nxt            = res >> 1;
    res_nxt[WIDTH-1]   = s;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      areg      <= '0;
      breg      <= '0;
      res       <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
      unique case (state)
        IDLE: begin
          if (accept) begin
            areg  <= a;
            breg  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          areg  <= areg >> 1;
          breg  <= breg >> 1;
          res   <= res_nxt;
          carry <= c;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum   <= res_nxt;
            cout  <= c;
`ifdef SERIAL_ADD_OVF_EN
            // Old carry is the carry into the MSB.
            ovf_q <= carry ^ c;
`endif
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1 instances).
// Expected values are hand computed; ovf expectations follow SERIAL_ADD_OVF_EN.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       busy;

  logic       in_valid1;
  logic       in_ready1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       out_valid1;
  logic       out_ready1;
  logic [0:0] sum1;
  logic       cout1;
  logic       ovf1;
  logic       busy1;

  int errors = 0;
  int checks = 0;

`ifdef SERIAL_ADD_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for in_ready, present operands, then count cycles to out_valid.
  task automatic start_op(input logic [7:0] va, input logic [7:0] vb,
                          input logic vc, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 10) begin
      tick();
      w++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    a = va;
    b = vb;
    cin = vc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 8'hAA;
    b = 8'h55;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] va,
                       input logic [7:0] vb, input logic vc,
                       input logic [7:0] es, input logic ec,
                       input logic eo);
    int lat;
    start_op(va, vb, vc, lat);
    check({tag, "_lat"}, lat, 8);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
    check({tag, "_busy"}, busy, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_low"}, out_valid, 1'b0);
    check({tag, "_idle_rdy"}, in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    in_valid1 = 1'b0;
    out_ready1 = 1'b0;
    a1 = '0;
    b1 = '0;
    cin1 = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", in_ready, 1'b1);

    do_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("3c_42", 8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0, 1'b0);
    do_op("80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, OVF_ON);
    do_op("7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF_ON);

    // Backpressure with a competing request that must not be taken.
    start_op(8'h55, 8'h0F, 1'b0, lat);
    check("bp_lat", lat, 8);
    in_valid = 1'b1;
    a = 8'h11;
    b = 8'h22;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1'b1);
      check("bp_sum", sum, 8'h64);
      check("bp_in_ready", in_ready, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_busy", busy, 1'b0);
    check("bp_sum_kept", sum, 8'h64);

    // Abort mid-RUN at bit 3.
    a = 8'hFF;
    b = 8'hFF;
    cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_valid", out_valid, 1'b0);
    check("abort_sum", sum, 8'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_cout", cout, 1'b0);
    do_op("01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // WIDTH=1 instance.
    lat = 0;
    while (!in_ready1 && lat < 10) begin
      tick();
      lat++;
    end
    check("w1_ready", in_ready1, 1'b1);
    a1 = 1'b1;
    b1 = 1'b1;
    cin1 = 1'b1;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 10) begin
      tick();
      lat++;
    end
    check("w1_lat", lat, 1);
    check("w1_sum", sum1, 1'b1);
    check("w1_cout", cout1, 1'b1);
    check("w1_ovf", ovf1, 1'b0);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("w1_ov_low", out_valid1, 1'b0);
    check("w1_ready_back", in_ready1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial multi-bit adder controller. It time-shares one full-adder cell (propagate/generate form, carry held in a flop) across WIDTH cycles to add two WIDTH-bit operands plus a carry-in. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It trades throughput for area: one adder cell replaces a WIDTH-bit ripple chain.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands a/b/cin valid
- in_ready  out  1  block can accept operands; high only in IDLE
- a  in  WIDTH  operand A, unsigned or two's complement
- b  in  WIDTH  operand B
- cin  in  1  carry-in to bit 0
- out_valid  out  1  sum/cout/ovf valid; high only in DONE
- out_ready  in  1  consumer accepts the result
- sum  out  WIDTH  result, a+b+cin mod 2^WIDTH
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow; see Configuration
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture a→shift reg A, b→shift reg B, cin→carry flop, clear bit counter. Go to RUN.
- RUN, one bit per cycle. Compute p=A[0]^B[0], g=A[0]&B[0], s=p^carry, c=g|(p&carry).
  - Shift s into the result register MSB, shift A and B right, carry<=c, counter+1.
  - When counter==WIDTH-1, this is the last bit: capture carry-into-MSB (the old carry) for ovf, then go to DONE.
- DONE: out_valid=1. sum, cout and ovf stay stable until out_ready=1; on that edge go to IDLE.
- in_valid outside IDLE is ignored. No new operands are captured and there is no queueing.
- Counter width is clog2(WIDTH) with a minimum of 1. For WIDTH=1, RUN lasts exactly one cycle.
- Reset values: in_ready=0 during the reset cycle, then 1. out_valid=0, busy=0, sum=0, cout=0, ovf=0. Carry and counter are cleared.
- rst in any state, including mid-RUN or DONE, aborts the operation. The next cycle is IDLE with all outputs at reset values, and the partial result is discarded.

## Timing
- Accept edge T (in_valid&&in_ready). RUN spans edges T+1..T+WIDTH, processing bit i at edge T+1+i.
- out_valid rises in the cycle after edge T+WIDTH. Latency from acceptance to result is WIDTH cycles.
- If out_ready=1 in the first DONE cycle, the block returns to IDLE at the next edge. in_ready=1 one cycle after the result handshake.
- Peak throughput is one add per WIDTH+2 cycles.
- sum/cout/ovf are registered and change only at the entry to DONE.
- busy is registered and equals (state!=IDLE).

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - ovf is set on entry to DONE to (carry into MSB) XOR (carry out of MSB).
  - ovf is valid with out_valid and cleared by reset.
- SERIAL_ADD_OVF_EN undefined:
  - The ovf port still exists but is tied to constant 0.
  - The MSB carry capture flop is not built.
  - All other behaviour is identical.

## Test plan
- WIDTH=8: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. out_valid first seen exactly 8 cycles after the accept edge.
- WIDTH=8: a=0x3C, b=0x42, cin=1 → sum=0x7F, cout=0, ovf=0. A back-to-back second op a=0x80, b=0x80, cin=0 is accepted one cycle after the result handshake → sum=0x00, cout=1, ovf=1 (0 if macro undefined).
- WIDTH=8: a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1 with SERIAL_ADD_OVF_EN, ovf=0 without.
- Backpressure: hold out_ready=0 for 5 DONE cycles → out_valid and sum stay stable. Meanwhile in_valid=1 with new operands stays unaccepted (in_ready=0). Raising out_ready returns the block to IDLE at the next edge.
- Reset mid-RUN: assert rst at bit 3 of an 8-bit add → next cycle IDLE, out_valid=0, sum=0, busy=0. A fresh add of 0x01+0x01+0 then yields 0x02, proving the stale carry was cleared.
- WIDTH=1: a=1, b=1, cin=1 → sum=1, cout=1, ovf=0. out_valid appears 1 cycle after acceptance.
